// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and stream framing constants for the instruction loader.
package loader_pkg;
    typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_DATA, S_WRITE, S_DONE, S_ERR} state_t;
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: byte stream in, instruction-memory write port and status out.
interface instr_mem_loader_if #(parameter int POS = 10);
    logic           START;
    logic [7:0]     BYTE_DATA;
    logic           BYTE_VALID;
    logic           BYTE_READY;
    logic           WR_EN;
    logic [POS-1:0] WR_ADDR;
    logic [31:0]    WR_DATA;
    logic           BUSY;
    logic           DONE;
    logic           ERROR;
    modport master (output START, BYTE_DATA, BYTE_VALID,
                    input BYTE_READY, WR_EN, WR_ADDR, WR_DATA, BUSY, DONE, ERROR);
    modport slave  (input START, BYTE_DATA, BYTE_VALID,
                    output BYTE_READY, WR_EN, WR_ADDR, WR_DATA, BUSY, DONE, ERROR);
endinterface

// File: rtl/byte_packer.sv
// byte_packer: assembles little-endian 32-bit words from accepted bytes; word_done flags the completing byte.
module byte_packer
    import loader_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        clr,
    input  logic        push,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        word_done
);
    logic [1:0]  idx_q, idx_d;
    logic [31:0] shift_q, shift_d;
    always_comb begin
        word_next = {byte_in, shift_q[31:8]};
        word_done = push && idx_q == 2'(BYTES_PER_WORD - 1);
        idx_d     = clr ? 2'd0 : push ? idx_q + 2'd1 : idx_q;
        shift_d   = push ? word_next : shift_q;
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: parses a counted little-endian byte stream and writes it word by word into instruction memory.
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int POSICIONES = 1024,
    parameter int POS        = $clog2(POSICIONES)
) (
    input logic               CLK,
    input logic               RESET,
    instr_mem_loader_if.slave bus
);
    localparam logic [16:0] MAX_N = 17'(POSICIONES);
    state_t         state_q, state_d;
    logic [15:0]    n_q, n_d, words_q, words_d, hdr_n;
    logic [POS-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]    wr_data_q, wr_data_d, word_next;
    logic           ready, accept, start_ok, word_done;
    byte_packer u_packer (
        .CLK       (CLK),
        .RESET     (RESET),
        .clr       (start_ok),
        .push      (accept && state_q == S_DATA),
        .byte_in   (bus.BYTE_DATA),
        .word_next (word_next),
        .word_done (word_done)
    );
    always_ff @(posedge CLK) begin
        if (RESET) state_q <= S_IDLE;
        else       state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: if (bus.START) state_d = S_HDR0;
            S_HDR0:  if (accept) state_d = S_HDR1;
            S_HDR1:  if (accept) state_d = hdr_n == 16'd0 ? S_DONE : {1'b0, hdr_n} > MAX_N ? S_ERR : S_DATA;
            S_DATA:  if (word_done) state_d = S_WRITE;
            S_WRITE: state_d = (words_q + 16'd1) < n_q ? S_DATA : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end
    always_comb begin
        ready          = state_q inside {S_HDR0, S_HDR1, S_DATA};
        start_ok       = bus.START && state_q inside {S_IDLE, S_DONE, S_ERR};
        accept         = ready && bus.BYTE_VALID;
        hdr_n          = {bus.BYTE_DATA, n_q[7:0]};
        bus.BYTE_READY = ready;
        bus.WR_EN      = state_q == S_WRITE;
        bus.BUSY       = state_q inside {S_HDR0, S_HDR1, S_DATA, S_WRITE};
        bus.DONE       = state_q == S_DONE;
        bus.ERROR      = state_q == S_ERR;
        bus.WR_ADDR    = wr_addr_q;
        bus.WR_DATA    = wr_data_q;
    end
    // Address/data are captured on the completing byte so they hold steady between strobes.
    always_comb begin
        n_d       = n_q;
        words_d   = words_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (start_ok) begin
            n_d       = '0;
            words_d   = '0;
            wr_addr_d = '0;
        end
        if (accept && state_q == S_HDR0) n_d = {8'h00, bus.BYTE_DATA};
        if (accept && state_q == S_HDR1) n_d = hdr_n;
        if (word_done) begin
            wr_addr_d = POS'(words_q);
            wr_data_d = word_next;
        end
        if (state_q == S_WRITE) words_d = words_q + 16'd1;
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            n_q       <= '0;
            words_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            n_q       <= n_d;
            words_q   <= words_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed streams checked against a stream-parsing model of the expected memory writes.
module tb_instr_mem_loader;
    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;
    instr_mem_loader_if #(.POS(10)) bus();
    instr_mem_loader #(.POSICIONES(1024)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));
    wr_t         exp_q[$];
    wr_t         e;
    int          compared = 0;
    int          mismatched = 0;
    int          wr_count = 0;
    int          last_addr = -1;
    int          log_addr[8];
    logic [31:0] log_data[8];
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask
    // Every write strobe must match the next write the model derived from the stream.
    always @(negedge CLK) begin
        if (bus.WR_EN) begin
            if (wr_count < 8) begin
                log_addr[wr_count] = int'(bus.WR_ADDR);
                log_data[wr_count] = bus.WR_DATA;
            end
            last_addr = int'(bus.WR_ADDR);
            wr_count++;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL stray_wr: strobe at addr %0h data %0h, want none", bus.WR_ADDR, bus.WR_DATA);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(bus.WR_ADDR), 64'(e.addr));
                chk("wr_data", 64'(bus.WR_DATA), 64'(e.data));
            end
        end
    end
    task automatic model(input logic [7:0] s[$], output logic ed, output logic ee, output int nw);
        int n;
        n  = int'({s[1], s[0]});
        ed = 1'b0;
        ee = 1'b0;
        nw = 0;
        if (n > 1024) ee = 1'b1;
        else begin
            ed = 1'b1;
            nw = n;
            for (int w = 0; w < n; w++)
                exp_q.push_back('{w, {s[2+4*w+3], s[2+4*w+2], s[2+4*w+1], s[2+4*w]}});
        end
    endtask
    task automatic pulse_start();
        @(negedge CLK);
        bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
    endtask
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge CLK);
        bus.BYTE_DATA  = b;
        bus.BYTE_VALID = 1'b1;
        while (!bus.BYTE_READY && t < 50) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 50) begin
            compared++;
            mismatched++;
            $display("FAIL byte_timeout: BYTE_READY stayed 0, want 1");
        end
        @(posedge CLK);
        #1 bus.BYTE_VALID = 1'b0;
    endtask
    task automatic drive(input logic [7:0] s[$], input int gap);
        foreach (s[i]) begin
            send_byte(s[i]);
            repeat (gap) @(negedge CLK);
        end
    endtask
    task automatic finish_chk(input string nm, input logic ed, input logic ee, input int nw, input int wc0);
        int t;
        t = 0;
        while (!(bus.DONE || bus.ERROR) && t < 20) begin
            @(negedge CLK);
            t++;
        end
        chk({nm, "_done"}, 64'(bus.DONE), 64'(ed));
        chk({nm, "_error"}, 64'(bus.ERROR), 64'(ee));
        chk({nm, "_busy"}, 64'(bus.BUSY), 64'd0);
        chk({nm, "_ready"}, 64'(bus.BYTE_READY), 64'd0);
        chk({nm, "_writes"}, 64'(wr_count - wc0), 64'(nw));
        chk({nm, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask
    task automatic reset_outputs_chk(input string nm);
        chk({nm, "_ready"}, 64'(bus.BYTE_READY), 64'd0);
        chk({nm, "_wr_en"}, 64'(bus.WR_EN), 64'd0);
        chk({nm, "_wr_addr"}, 64'(bus.WR_ADDR), 64'd0);
        chk({nm, "_wr_data"}, 64'(bus.WR_DATA), 64'd0);
        chk({nm, "_busy"}, 64'(bus.BUSY), 64'd0);
        chk({nm, "_done"}, 64'(bus.DONE), 64'd0);
        chk({nm, "_error"}, 64'(bus.ERROR), 64'd0);
    endtask
    initial begin
        logic [7:0] s1[$], s0[$], serr[$], sbig[$], part[$], rest[$];
        logic       ed, ee;
        int         nw, wc0;
        s1   = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        s0   = '{8'h00, 8'h00};
        serr = '{8'h01, 8'h04};
        part = '{8'h02, 8'h00, 8'h13, 8'h00};
        rest = '{8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        bus.START      = 1'b0;
        bus.BYTE_VALID = 1'b0;
        bus.BYTE_DATA  = 8'h00;
        repeat (2) @(negedge CLK);
        reset_outputs_chk("rst0");
        RESET = 1'b0;
        // Two-word load, back-to-back bytes.
        model(s1, ed, ee, nw);
        wc0 = wr_count;
        pulse_start();
        drive(s1, 0);
        finish_chk("basic", ed, ee, nw, wc0);
        chk("basic_addr0", 64'(log_addr[0]), 64'd0);
        chk("basic_data0", 64'(log_data[0]), 64'h0000_0013);
        chk("basic_addr1", 64'(log_addr[1]), 64'd1);
        chk("basic_data1", 64'(log_data[1]), 64'h0010_0093);
        // Restart from DONE clears status and address, then an empty load.
        pulse_start();
        chk("restart_addr", 64'(bus.WR_ADDR), 64'd0);
        chk("restart_done", 64'(bus.DONE), 64'd0);
        chk("restart_busy", 64'(bus.BUSY), 64'd1);
        model(s0, ed, ee, nw);
        wc0 = wr_count;
        drive(s0, 0);
        @(negedge CLK);
        chk("empty_done_fast", 64'(bus.DONE), 64'd1);
        finish_chk("empty", ed, ee, nw, wc0);
        // Oversized count goes to ERR; next START clears it.
        model(serr, ed, ee, nw);
        wc0 = wr_count;
        pulse_start();
        drive(serr, 0);
        finish_chk("oversize", ed, ee, nw, wc0);
        chk("oversize_ee_lit", 64'(bus.ERROR), 64'd1);
        pulse_start();
        chk("err_clear", 64'(bus.ERROR), 64'd0);
        chk("err_restart_busy", 64'(bus.BUSY), 64'd1);
        model(s0, ed, ee, nw);
        wc0 = wr_count;
        drive(s0, 0);
        finish_chk("after_err", ed, ee, nw, wc0);
        // Same stream with two idle cycles after every byte.
        model(s1, ed, ee, nw);
        wc0 = wr_count;
        pulse_start();
        drive(s1, 2);
        finish_chk("gaps", ed, ee, nw, wc0);
        // Reset mid-word: partial word must vanish.
        pulse_start();
        drive(part, 0);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        reset_outputs_chk("rst_mid");
        RESET = 1'b0;
        model(s1, ed, ee, nw);
        wc0 = wr_count;
        pulse_start();
        drive(s1, 0);
        finish_chk("post_rst", ed, ee, nw, wc0);
        // START during DATA is ignored.
        model(s1, ed, ee, nw);
        wc0 = wr_count;
        pulse_start();
        drive(part, 0);
        pulse_start();
        chk("start_in_data_busy", 64'(bus.BUSY), 64'd1);
        drive(rest, 0);
        finish_chk("start_in_data", ed, ee, nw, wc0);
        // Full memory: N = POSICIONES is legal and ends at the top address.
        sbig = '{8'h00, 8'h04};
        for (int i = 0; i < 4096; i++) sbig.push_back(8'($urandom));
        model(sbig, ed, ee, nw);
        wc0 = wr_count;
        pulse_start();
        drive(sbig, 0);
        finish_chk("full", ed, ee, nw, wc0);
        chk("full_last_addr", 64'(last_addr), 64'd1023);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
